// File: rtl/eh2_pkg.sv
// eh2_pkg: types shared by the DCCM ECC write-back scheduler.
//   eh2_ecc_wrbk_pkt_t   - one queued correction (bank flags, addresses, data)
//   eh2_ecc_wrbk_state_e - write-back FSM states
// The packet field widths are the default DCCM widths. Any module that
// overrides ADDR_W/DATA_W must keep them no wider than these.
package eh2_pkg;

  localparam int unsigned ECC_ADDR_W = 16;
  localparam int unsigned ECC_DATA_W = 32;

  typedef struct packed {
    logic                  lo;
    logic                  hi;
    logic [ECC_ADDR_W-1:0] addr_lo;
    logic [ECC_ADDR_W-1:0] addr_hi;
    logic [ECC_DATA_W-1:0] data_lo;
    logic [ECC_DATA_W-1:0] data_hi;
  } eh2_ecc_wrbk_pkt_t;

  typedef enum logic [1:0] {
    ECC_IDLE  = 2'd0,
    ECC_WR_LO = 2'd1,
    ECC_WR_HI = 2'd2
  } eh2_ecc_wrbk_state_e;

endpackage

// File: rtl/eh2_lsu_ecc_wrbk_fifo.sv
// eh2_lsu_ecc_wrbk_fifo: DEPTH-entry circular buffer of correction packets.
//   clk, rst_l      - clock and synchronous active-low reset
//   push, wr_pkt    - write wr_pkt at the tail (caller guarantees room)
//   pop             - retire the head entry (caller guarantees non-empty)
//   head_pkt        - current head entry
//   next_lo         - lo flag of the entry behind the head (valid when count > 1)
//   count           - current occupancy
//   full, empty     - registered from the next-state occupancy
module eh2_lsu_ecc_wrbk_fifo
  import eh2_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   push,
  input  logic                   pop,
  input  eh2_ecc_wrbk_pkt_t      wr_pkt,
  output eh2_ecc_wrbk_pkt_t      head_pkt,
  output logic                   next_lo,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  eh2_ecc_wrbk_pkt_t mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_nxt;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    rd_nxt   = rd_ptr_q + PTR_W'(1);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_nxt : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid. A push
  // while full (only when the head pops the same cycle) overwrites the
  // retiring head slot, which is read combinationally before the edge.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_pkt;
    end
  end

  assign head_pkt = mem_q[rd_ptr_q];
  assign next_lo  = mem_q[rd_nxt].lo;
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: rtl/eh2_lsu_ecc_wrbk_ctl.sv
// eh2_lsu_ecc_wrbk_ctl: queues DC5 single-bit ECC corrections and writes the
// corrected words back through the shared DCCM write port.
//   ecc_err_*          - correction request (lo/hi bank flags, addresses, data)
//   dma_dccm_spec_wen  - DMA owns the port this cycle (highest priority)
//   stbuf_wr_req/gnt   - store-buffer request and grant
//   ecc_wr_en/addr/data- one word-aligned 32-bit correction write per grant
//   ecc_wrbk_done      - final write of an entry
//   ecc_q_full/empty   - queue status; ecc_drop_sticky - a request was lost
module eh2_lsu_ecc_wrbk_ctl
  import eh2_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              ecc_err_valid,
  input  logic              ecc_err_lo,
  input  logic              ecc_err_hi,
  input  logic [ADDR_W-1:0] ecc_err_addr_lo,
  input  logic [ADDR_W-1:0] ecc_err_addr_hi,
  input  logic [DATA_W-1:0] ecc_err_data_lo,
  input  logic [DATA_W-1:0] ecc_err_data_hi,
  input  logic              dma_dccm_spec_wen,
  input  logic              stbuf_wr_req,
  output logic              stbuf_wr_gnt,
  output logic              ecc_wr_en,
  output logic [ADDR_W-1:0] ecc_wr_addr,
  output logic [DATA_W-1:0] ecc_wr_data,
  output logic              ecc_wrbk_done,
  output logic              ecc_q_full,
  output logic              ecc_q_empty,
  output logic              ecc_drop_sticky
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  eh2_ecc_wrbk_state_e state_q, state_d;
  logic [STV_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic                drop_sticky_q, drop_sticky_d;

  eh2_ecc_wrbk_pkt_t   wr_pkt;
  eh2_ecc_wrbk_pkt_t   head_pkt;
  logic                next_lo;
  logic [CNT_W-1:0]    q_count;
  logic                q_full;
  logic                q_empty;
  logic                push;
  logic                pop;
  logic                req_valid;
  logic                force_sb;
  logic                wr_lo_bank;
  logic [ADDR_W-1:0]   bank_addr;

  eh2_lsu_ecc_wrbk_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_l    (rst_l),
    .push     (push),
    .pop      (pop),
    .wr_pkt   (wr_pkt),
    .head_pkt (head_pkt),
    .next_lo  (next_lo),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

  always_comb begin
    wr_pkt         = '0;
    wr_pkt.lo      = ecc_err_lo;
    wr_pkt.hi      = ecc_err_hi;
    wr_pkt.addr_lo = ECC_ADDR_W'(ecc_err_addr_lo);
    wr_pkt.addr_hi = ECC_ADDR_W'(ecc_err_addr_hi);
    wr_pkt.data_lo = ECC_DATA_W'(ecc_err_data_lo);
    wr_pkt.data_hi = ECC_DATA_W'(ecc_err_data_hi);
  end

  // Port arbitration: DMA, then a starved store buffer, then ECC, then store buffer.
  always_comb begin
    force_sb     = (starve_cnt_q == STV_W'(STARVE_MAX)) && stbuf_wr_req;
    ecc_wr_en    = 1'b0;
    stbuf_wr_gnt = 1'b0;
    if (!dma_dccm_spec_wen) begin
      if (force_sb) begin
        stbuf_wr_gnt = 1'b1;
      end else if (state_q != ECC_IDLE) begin
        ecc_wr_en = 1'b1;
      end else begin
        stbuf_wr_gnt = stbuf_wr_req;
      end
    end

    wr_lo_bank  = (state_q == ECC_WR_LO);
    bank_addr   = wr_lo_bank ? ADDR_W'(head_pkt.addr_lo) : ADDR_W'(head_pkt.addr_hi);
    ecc_wr_addr = '0;
    ecc_wr_data = '0;
    if (ecc_wr_en) begin
      ecc_wr_addr = {bank_addr[ADDR_W-1:2], 2'b00};
      ecc_wr_data = wr_lo_bank ? DATA_W'(head_pkt.data_lo) : DATA_W'(head_pkt.data_hi);
    end
    ecc_wrbk_done = ecc_wr_en && (!wr_lo_bank || !head_pkt.hi);

    // A full queue still accepts a request when the head retires this cycle.
    req_valid     = ecc_err_valid && (ecc_err_lo || ecc_err_hi);
    pop           = ecc_wrbk_done;
    push          = req_valid && (!q_full || ecc_wrbk_done);
    drop_sticky_d = drop_sticky_q || (req_valid && !push);
  end

  // After retiring the head, only an entry already queued is started at once;
  // one pushed in the same cycle goes through IDLE to keep the 2-cycle latency.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ECC_IDLE: begin
        if (!q_empty) begin
          state_d = head_pkt.lo ? ECC_WR_LO : ECC_WR_HI;
        end
      end
      ECC_WR_LO, ECC_WR_HI: begin
        if (ecc_wr_en) begin
          if (!ecc_wrbk_done) begin
            state_d = ECC_WR_HI;
          end else if (q_count > CNT_W'(1)) begin
            state_d = next_lo ? ECC_WR_LO : ECC_WR_HI;
          end else begin
            state_d = ECC_IDLE;
          end
        end
      end
      default: state_d = ECC_IDLE;
    endcase
  end

  // Only ECC-caused denials age the store buffer; DMA denials hold the count.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!stbuf_wr_req || stbuf_wr_gnt) begin
      starve_cnt_d = '0;
    end else if (ecc_wr_en && (starve_cnt_q != STV_W'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q       <= ECC_IDLE;
      starve_cnt_q  <= '0;
      drop_sticky_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      drop_sticky_q <= drop_sticky_d;
    end
  end

  assign ecc_q_full      = q_full;
  assign ecc_q_empty     = q_empty && (state_q == ECC_IDLE);
  assign ecc_drop_sticky = drop_sticky_q;

endmodule

// File: doc/eh2_lsu_ecc_wrbk_ctl.md
Name: eh2_lsu_ecc_wrbk_ctl

Overview:
Write-back scheduler for DCCM single-bit ECC corrections. It queues corrected load data (lo and/or hi bank) flagged at DC5. It then shares the single DCCM write port with DMA speculative writes and store-buffer drains. It sits in the LSU between the ECC decode/correct datapath and the DCCM write mux, and it issues one 32-bit corrected word per granted cycle.

Parameters:
DEPTH, 2, correction queue entries (power of 2, >=2)
ADDR_W, 16, DCCM address width (pt.DCCM_BITS)
DATA_W, 32, DCCM data width (pt.DCCM_DATA_WIDTH)
STARVE_MAX, 4, consecutive store-buffer denials before a forced store-buffer grant

Ports:
clk  in  1  core clock
rst_l  in  1  reset; active-low; synchronous
ecc_err_valid  in  1  DC5 single-error correction request
ecc_err_lo  in  1  lo bank needs rewrite
ecc_err_hi  in  1  hi bank needs rewrite
ecc_err_addr_lo  in  ADDR_W  lo bank byte address
ecc_err_addr_hi  in  ADDR_W  hi bank byte address
ecc_err_data_lo  in  DATA_W  corrected lo word
ecc_err_data_hi  in  DATA_W  corrected hi word
dma_dccm_spec_wen  in  1  DMA owns the write port this cycle
stbuf_wr_req  in  1  store buffer requests the write port
stbuf_wr_gnt  out  1  store buffer granted
ecc_wr_en  out  1  correction write issued this cycle
ecc_wr_addr  out  ADDR_W  correction address; bits [1:0] forced to 0
ecc_wr_data  out  DATA_W  corrected word
ecc_wrbk_done  out  1  pulse on the final write of an entry
ecc_q_full  out  1  queue full (registered)
ecc_q_empty  out  1  queue empty and FSM idle
ecc_drop_sticky  out  1  a request was dropped; set only, cleared by reset

Behaviour:
- Reset (rst_l=0 sampled at posedge):
  - Pointers, count and starve counter go to 0.
  - FSM goes to IDLE.
  - ecc_drop_sticky=0.
  - All outputs read 0, except ecc_q_empty=1.
  - Reset mid-operation discards every queued and in-flight entry.
- Enqueue:
  - An entry is written when ecc_err_valid & (ecc_err_lo|ecc_err_hi), and either count<DEPTH or the head's final write completes this same cycle.
  - A request with valid=1 but lo=hi=0 is ignored.
  - A request with no room is dropped and sets ecc_drop_sticky next cycle.
- Entry contents: lo flag, hi flag, both addresses, both data words.
- FSM states IDLE, WR_LO, WR_HI:
  - IDLE -> WR_LO if the head entry has lo=1.
  - IDLE -> WR_HI if the head entry has lo=0 and hi=1.
  - IDLE waits while the queue is empty.
  - WR_LO on grant -> WR_HI if hi=1; otherwise the entry is popped and the FSM returns to IDLE (or starts the next head at once).
  - WR_HI on grant -> pop, then IDLE or the next head.
  - With no grant, the state is held.
  - The enqueue-to-first-write minimum latency is 2 cycles (enqueue edge, then the IDLE->WR_x edge, then issue).
- Arbitration (combinational, same cycle):
  - Priority 1: dma_dccm_spec_wen=1 -> ecc_wr_en=0 and stbuf_wr_gnt=0.
  - Priority 2: starve_cnt==STARVE_MAX and stbuf_wr_req -> stbuf_wr_gnt=1 and starve_cnt resets.
  - Priority 3: FSM in WR_LO/WR_HI -> ecc_wr_en=1.
  - Priority 4: otherwise stbuf_wr_gnt=stbuf_wr_req.
- Starve counter:
  - Increments (saturating at STARVE_MAX) when stbuf_wr_req=1 is denied because of an ECC write.
  - Clears on any store-buffer grant or when stbuf_wr_req=0.
  - DMA-caused denials do not count.
- ecc_wr_addr = {addr[ADDR_W-1:2],2'b00} of the current bank; ecc_wr_data = that bank's data.
- ecc_wrbk_done = ecc_wr_en and the write is the last for its entry.
- ecc_q_full and ecc_q_empty are registered, derived from the next-state count.
- Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits wide.

Decomposition:
- Shared package (eh2_pkg): the struct eh2_ecc_wrbk_pkt_t {lo, hi, addr_lo, addr_hi, data_lo, data_hi} and the enum for the FSM states.
- One sub-module: eh2_lsu_ecc_wrbk_fifo (DEPTH-entry circular buffer with push, pop, full and empty).
- The arbiter and FSM stay in the top module.

Test Plan:
- Single lo error: addr_lo=0x0104, data_lo=0xDEADBEEF, no contention -> ecc_wr_en with addr 0x0104 and data 0xDEADBEEF exactly 2 cycles after enqueue; done=1 the same cycle; q_empty=1 the cycle after.
- Dual error: lo=0x0200/0x11111111 and hi=0x0204/0x22222222 -> two consecutive ecc_wr_en cycles in lo-then-hi order; done only on the second.
- DMA contention: dma_dccm_spec_wen held high 3 cycles during WR_LO -> no ecc_wr_en and no stbuf_wr_gnt for those cycles; the write issues the cycle DMA drops; starve_cnt unchanged.
- Starvation: queue kept full with stbuf_wr_req=1 continuously -> stbuf_wr_gnt=1 on the 5th request cycle; ECC writes then resume.
- Overflow: 3 requests in consecutive cycles with DEPTH=2 and DMA blocking -> third dropped; ecc_drop_sticky=1 and stays 1; exactly 2 entries written back.
- Reset mid-operation: rst_l=0 during WR_HI -> next cycle ecc_wr_en=0, q_empty=1, drop_sticky=0; no further writes.
